// File: rtl/elevator_call_scheduler.sv
// SCAN-ordered elevator call scheduler: latches floor calls, tracks car position
// from floor ticks, and sequences move/door commands.
module elevator_call_scheduler #(
  parameter int NUM_FLOORS   = 8,
  parameter int FLOOR_W      = 3,
  parameter int DWELL_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] call_req,
  input  logic                  floor_tick,
  output logic                  move_up,
  output logic                  move_down,
  output logic                  door_open,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);

  localparam int DWELL_W = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR} state_t;

  state_t                  state, state_nx;
  logic [FLOOR_W-1:0]      floor_nx, floor_up, floor_dn;
  logic [NUM_FLOORS-1:0]   pending_nx;
  logic [DWELL_W-1:0]      dwell, dwell_nx;
  logic                    dir_nx;
  logic                    above, below, here;

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int unsigned f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) > current_floor)) above = 1'b1;
      if (pending[f] && (FLOOR_W'(f) < current_floor)) below = 1'b1;
    end
  end

  assign here     = pending[current_floor];
  assign floor_up = current_floor + FLOOR_W'(1);
  assign floor_dn = current_floor - FLOOR_W'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      pending       <= '0;
      dir_up        <= 1'b1;
      dwell         <= '0;
    end else begin
      state         <= state_nx;
      current_floor <= floor_nx;
      pending       <= pending_nx;
      dir_up        <= dir_nx;
      dwell         <= dwell_nx;
    end
  end

  always_comb begin
    state_nx = state;
    floor_nx = current_floor;
    dir_nx   = dir_up;
    dwell_nx = dwell;
    case (state)
      IDLE: begin
        if (here) begin
          state_nx = DOOR;
          dwell_nx = DWELL_LOAD;
        end else if (above && (dir_up || !below)) begin
          state_nx = MOVE_UP;
          dir_nx   = 1'b1;
        end else if (below) begin
          state_nx = MOVE_DOWN;
          dir_nx   = 1'b0;
        end
      end
      MOVE_UP: begin
        if (floor_tick) begin
          if (current_floor == TOP_FLOOR) begin
            state_nx = IDLE;
          end else begin
            floor_nx = floor_up;
            // A call landing on the same edge as the arrival still stops the car.
            if (pending[floor_up] || call_req[floor_up]) begin
              state_nx = DOOR;
              dwell_nx = DWELL_LOAD;
            end
          end
        end
      end
      MOVE_DOWN: begin
        if (floor_tick) begin
          if (current_floor == '0) begin
            state_nx = IDLE;
          end else begin
            floor_nx = floor_dn;
            if (pending[floor_dn] || call_req[floor_dn]) begin
              state_nx = DOOR;
              dwell_nx = DWELL_LOAD;
            end
          end
        end
      end
      DOOR: begin
        if (call_req[current_floor]) begin
          dwell_nx = DWELL_LOAD;
        end else if (dwell == '0) begin
          state_nx = IDLE;
        end else begin
          dwell_nx = dwell - DWELL_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase

    // The floor being served never holds a pending bit, even if re-called this cycle.
    pending_nx = pending | call_req;
    if (state_nx == DOOR) pending_nx[floor_nx] = 1'b0;
  end

  always_comb begin
    move_up   = (state == MOVE_UP);
    move_down = (state == MOVE_DOWN);
    door_open = (state == DOOR);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed vector bench for elevator_call_scheduler (8 floors, 4-cycle dwell).
module tb_elevator_call_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] call_req;
  logic       floor_tick;
  logic       move_up, move_down, door_open, dir_up, busy;
  logic [2:0] current_floor;
  logic [7:0] pending;

  int nvec = 0;
  int nmis = 0;

  elevator_call_scheduler #(
    .NUM_FLOORS(8),
    .FLOOR_W(3),
    .DWELL_CYCLES(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .call_req(call_req),
    .floor_tick(floor_tick),
    .move_up(move_up),
    .move_down(move_down),
    .door_open(door_open),
    .current_floor(current_floor),
    .pending(pending),
    .dir_up(dir_up),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] call;
    logic       tick;
    logic       mu, md, door;
    logic [2:0] fl;
    logic [7:0] pend;
    logic       dir, bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic [7:0] call, input logic tick,
                              input logic mu, input logic md, input logic door,
                              input logic [2:0] fl, input logic [7:0] pend,
                              input logic dir, input logic bsy);
    vec_t v;
    v.rst = rst; v.call = call; v.tick = tick;
    v.mu = mu; v.md = md; v.door = door; v.fl = fl; v.pend = pend; v.dir = dir; v.bsy = bsy;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic emu, input logic emd, input logic ed,
                       input logic [2:0] ef, input logic [7:0] ep, input logic edir,
                       input logic eb);
    nvec++;
    if ({move_up, move_down, door_open, current_floor, pending, dir_up, busy} !==
        {emu, emd, ed, ef, ep, edir, eb}) begin
      nmis++;
      $display("FAIL %s: got mu=%b md=%b door=%b floor=%0d pend=%h dir=%b busy=%b, expected mu=%b md=%b door=%b floor=%0d pend=%h dir=%b busy=%b",
               name, move_up, move_down, door_open, current_floor, pending, dir_up, busy,
               emu, emd, ed, ef, ep, edir, eb);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    nvec++;
    if (got != exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input logic [7:0] c, input logic t);
    call_req   = c;
    floor_tick = t;
    @(posedge clk);
    #1;
    call_req   = '0;
    floor_tick = 1'b0;
  endtask

  int door_cycles;

  initial begin
    reset = 1'b1; call_req = '0; floor_tick = 1'b0;

    // Single call to floor 5, then an ignored tick in IDLE.
    add(1, 8'h00, 0, 0,0,0, 0, 8'h00, 1, 0);
    add(0, 8'h20, 0, 0,0,0, 0, 8'h20, 1, 0);
    add(0, 8'h00, 0, 1,0,0, 0, 8'h20, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 1, 8'h20, 1, 1);
    add(0, 8'h00, 0, 1,0,0, 1, 8'h20, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 2, 8'h20, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 3, 8'h20, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 4, 8'h20, 1, 1);
    add(0, 8'h00, 1, 0,0,1, 5, 8'h00, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0,0,1, 5, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,0,0, 5, 8'h00, 1, 0);
    add(0, 8'h00, 1, 0,0,0, 5, 8'h00, 1, 0);
    // Call at the current floor; tick during DOOR ignored.
    add(1, 8'h00, 0, 0,0,0, 0, 8'h00, 1, 0);
    add(0, 8'h01, 0, 0,0,0, 0, 8'h01, 1, 0);
    add(0, 8'h00, 0, 0,0,1, 0, 8'h00, 1, 1);
    add(0, 8'h00, 1, 0,0,1, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,0,1, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,0,1, 0, 8'h00, 1, 1);
    add(0, 8'h00, 0, 0,0,0, 0, 8'h00, 1, 0);
    // SCAN: up to 6 with floor 1 pending, then down; call 4 lands with the tick reaching 4.
    add(0, 8'h40, 0, 0,0,0, 0, 8'h40, 1, 0);
    add(0, 8'h00, 0, 1,0,0, 0, 8'h40, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 1, 8'h40, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 2, 8'h40, 1, 1);
    add(0, 8'h02, 1, 1,0,0, 3, 8'h42, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 4, 8'h42, 1, 1);
    add(0, 8'h00, 1, 1,0,0, 5, 8'h42, 1, 1);
    add(0, 8'h00, 1, 0,0,1, 6, 8'h02, 1, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0,0,1, 6, 8'h02, 1, 1);
    add(0, 8'h00, 0, 0,0,0, 6, 8'h02, 1, 0);
    add(0, 8'h00, 0, 0,1,0, 6, 8'h02, 0, 1);
    add(0, 8'h00, 1, 0,1,0, 5, 8'h02, 0, 1);
    add(0, 8'h10, 1, 0,0,1, 4, 8'h02, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0,0,1, 4, 8'h02, 0, 1);
    add(0, 8'h00, 0, 0,0,0, 4, 8'h02, 0, 0);
    add(0, 8'h00, 0, 0,1,0, 4, 8'h02, 0, 1);
    add(0, 8'h00, 1, 0,1,0, 3, 8'h02, 0, 1);
    add(0, 8'h00, 1, 0,1,0, 2, 8'h02, 0, 1);
    add(0, 8'h00, 1, 0,0,1, 1, 8'h00, 0, 1);
    for (int i = 0; i < 3; i++) add(0, 8'h00, 0, 0,0,1, 1, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0,0,0, 1, 8'h00, 0, 0);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      call_req   = vecs[i].call;
      floor_tick = vecs[i].tick;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].mu, vecs[i].md, vecs[i].door, vecs[i].fl,
            vecs[i].pend, vecs[i].dir, vecs[i].bsy);
    end
    reset = 1'b0; call_req = '0; floor_tick = 1'b0;

    // Dwell restart: re-call floor 2 in the second door cycle.
    step(8'h04, 0);
    step(8'h00, 0);
    check("restart_move", 1,0,0, 1, 8'h00 | 8'h04, 1, 1);
    step(8'h00, 1);
    check("restart_door", 0,0,1, 2, 8'h00, 1, 1);
    door_cycles = 1;
    step(8'h00, 0);
    if (door_open) door_cycles++;
    step(8'h04, 0);
    check("restart_absorb", 0,0,1, 2, 8'h00, 1, 1);
    if (door_open) door_cycles++;
    for (int i = 0; i < 16; i++) begin
      step(8'h00, 0);
      if (!door_open) break;
      door_cycles++;
    end
    check_int("restart_len", door_cycles, 6);
    check("restart_idle", 0,0,0, 2, 8'h00, 1, 0);

    // Reset mid-move: MOVE_DOWN at floor 5 with floors 0 and 7 pending.
    step(8'h40, 0);
    step(8'h00, 0);
    for (int i = 0; i < 4; i++) step(8'h00, 1);
    check("arrive6", 0,0,1, 6, 8'h00, 1, 1);
    for (int i = 0; i < 4; i++) step(8'h00, 0);
    step(8'h01, 0);
    step(8'h00, 0);
    step(8'h80, 1);
    check("pre_reset", 0,1,0, 5, 8'h81, 0, 1);
    #2 reset = 1'b1;
    #1 check("async_reset", 0,0,0, 0, 8'h00, 1, 0);
    call_req = 8'h04; floor_tick = 1'b1;
    @(posedge clk);
    #1 check("held_reset", 0,0,0, 0, 8'h00, 1, 0);
    reset = 1'b0; call_req = '0; floor_tick = 1'b0;
    @(posedge clk);
    #1 check("post_reset", 0,0,0, 0, 8'h00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
